// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared phase encodings and light codes for the intersection phase scheduler.
package intersection_phase_scheduler_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_TO_EW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_TO_NS = 3'd5
  } phase_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Light bus pairs: {EW, NS}
  localparam logic [5:0] LIGHTS_NS_GREEN  = {RED, GRN};
  localparam logic [5:0] LIGHTS_NS_YELLOW = {RED, YEL};
  localparam logic [5:0] LIGHTS_ALL_RED   = {RED, RED};
  localparam logic [5:0] LIGHTS_EW_GREEN  = {GRN, RED};
  localparam logic [5:0] LIGHTS_EW_YELLOW = {YEL, RED};

endpackage

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Per-phase tick counter: counts tick cycles since the last phase change and
// reports whether the current tick completes a duration of t_a or t_b ticks.
module intersection_phase_scheduler_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] t_a,
  input  logic [CNT_W-1:0] t_b,
  output logic [CNT_W-1:0] elapsed,
  output logic             hit_a,
  output logic             hit_b
);

  logic [CNT_W:0] elapsed_inc;

  // One extra bit so the +1 compare cannot wrap at saturation.
  assign elapsed_inc = {1'b0, elapsed} + {{CNT_W{1'b0}}, 1'b1};
  assign hit_a       = tick && (elapsed_inc >= {1'b0, t_a});
  assign hit_b       = tick && (elapsed_inc >= {1'b0, t_b});

  // Elapsed counter: cleared on phase change, counts ticks, saturates at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      elapsed <= '0;
    end else if (clr) begin
      elapsed <= '0;
    end else if (tick && (elapsed != {CNT_W{1'b1}})) begin
      elapsed <= elapsed_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Demand-driven NS/EW phase sequencer with detector gap-out, max-green
// extension, latched pedestrian walk service and emergency preemption.
module intersection_phase_scheduler
  import intersection_phase_scheduler_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned T_MIN_GREEN = 5,
  parameter int unsigned T_MAX_GREEN = 20,
  parameter int unsigned T_YELLOW    = 2,
  parameter int unsigned T_ALL_RED   = 1,
  parameter int unsigned T_WALK      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       req_ns,
  input  logic       req_ew,
  input  logic       ped_ns,
  input  logic       ped_ew,
  input  logic       preempt,
  input  logic       preempt_dir,
  output logic [5:0] lights,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] T_MIN_C  = CNT_W'(T_MIN_GREEN);
  localparam logic [CNT_W-1:0] T_MAX_C  = CNT_W'(T_MAX_GREEN);
  localparam logic [CNT_W-1:0] T_YEL_C  = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] T_AR_C   = CNT_W'(T_ALL_RED);
  localparam logic [CNT_W-1:0] T_WALK_C = CNT_W'(T_WALK);

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] t_sel;
  logic             hit_a, hit_max;
  logic             ped_ns_q, ped_ew_q;
  logic             walk_ns_f, walk_ew_f;
  logic             demand_ns, demand_ew;
  logic             enter_ns, enter_ew;

  assign demand_ns = req_ns | ped_ns_q;
  assign demand_ew = req_ew | ped_ew_q;
  assign enter_ns  = (state_d == NS_GREEN) && (state_q != NS_GREEN);
  assign enter_ew  = (state_d == EW_GREEN) && (state_q != EW_GREEN);

  intersection_phase_scheduler_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state_d != state_q),
    .tick    (tick),
    .t_a     (t_sel),
    .t_b     (T_MAX_C),
    .elapsed (elapsed),
    .hit_a   (hit_a),
    .hit_b   (hit_max)
  );

  // Select the primary duration for the current phase (min green, yellow or all-red).
  always_comb begin
    t_sel = T_MIN_C;
    case (state_q)
      NS_YELLOW, EW_YELLOW: t_sel = T_YEL_C;
      RED_TO_EW, RED_TO_NS: t_sel = T_AR_C;
      default:              t_sel = T_MIN_C;
    endcase
  end

  // Phase register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= NS_GREEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-phase logic: preemption first, then demand-driven green exit, then fixed timing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GREEN: begin
        if (preempt) begin
          if (preempt_dir) state_d = NS_YELLOW;
        end else if (demand_ew && hit_a && (!req_ns || hit_max)) begin
          state_d = NS_YELLOW;
        end
      end
      NS_YELLOW: if (hit_a) state_d = RED_TO_EW;
      RED_TO_EW: if (hit_a) state_d = (preempt && !preempt_dir) ? NS_GREEN : EW_GREEN;
      EW_GREEN: begin
        if (preempt) begin
          if (!preempt_dir) state_d = EW_YELLOW;
        end else if (demand_ns && hit_a && (!req_ew || hit_max)) begin
          state_d = EW_YELLOW;
        end
      end
      EW_YELLOW: if (hit_a) state_d = RED_TO_NS;
      RED_TO_NS: if (hit_a) state_d = (preempt && preempt_dir) ? EW_GREEN : NS_GREEN;
      default:   state_d = NS_GREEN;
    endcase
  end

  // Pedestrian latches and walk flags: a latched or same-cycle press is served on green entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_ns_q  <= 1'b0;
      ped_ew_q  <= 1'b0;
      walk_ns_f <= 1'b0;
      walk_ew_f <= 1'b0;
    end else begin
      if (enter_ns) begin
        walk_ns_f <= ped_ns_q | ped_ns;
        ped_ns_q  <= 1'b0;
      end else if (ped_ns) begin
        ped_ns_q  <= 1'b1;
      end
      if (enter_ew) begin
        walk_ew_f <= ped_ew_q | ped_ew;
        ped_ew_q  <= 1'b0;
      end else if (ped_ew) begin
        ped_ew_q  <= 1'b1;
      end
    end
  end

  // Output decode from registered phase; unused codes show NS green.
  always_comb begin
    lights = LIGHTS_NS_GREEN;
    case (state_q)
      NS_GREEN:  lights = LIGHTS_NS_GREEN;
      NS_YELLOW: lights = LIGHTS_NS_YELLOW;
      RED_TO_EW: lights = LIGHTS_ALL_RED;
      EW_GREEN:  lights = LIGHTS_EW_GREEN;
      EW_YELLOW: lights = LIGHTS_EW_YELLOW;
      RED_TO_NS: lights = LIGHTS_ALL_RED;
      default:   lights = LIGHTS_NS_GREEN;
    endcase
  end

  assign walk_ns = (state_q == NS_GREEN) && walk_ns_f && (elapsed < T_WALK_C) && !preempt;
  assign walk_ew = (state_q == EW_GREEN) && walk_ew_f && (elapsed < T_WALK_C) && !preempt;
  assign phase   = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with hand-computed expectations.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b1;
  logic       req_ns = 1'b0;
  logic       req_ew = 1'b0;
  logic       ped_ns = 1'b0;
  logic       ped_ew = 1'b0;
  logic       preempt = 1'b0;
  logic       preempt_dir = 1'b0;
  logic [5:0] lights;
  logic       walk_ns;
  logic       walk_ew;
  logic [2:0] phase;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  intersection_phase_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .req_ns      (req_ns),
    .req_ew      (req_ew),
    .ped_ns      (ped_ns),
    .ped_ew      (ped_ew),
    .preempt     (preempt),
    .preempt_dir (preempt_dir),
    .lights      (lights),
    .walk_ns     (walk_ns),
    .walk_ew     (walk_ew),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    tick        = 1'b1;
    req_ns      = 1'b0;
    req_ew      = 1'b0;
    ped_ns      = 1'b0;
    ped_ew      = 1'b0;
    preempt     = 1'b0;
    preempt_dir = 1'b0;
    step(2);
    reset_n     = 1'b1;
  endtask

  // Both approaches demanding: NSG 20, NSY 2, all-red 1, EWG 20, EWY 2, all-red 1.
  function automatic logic [7:0] exp_phase3(input int i);
    int m;
    m = i % 46;
    if (m < 20)      return 8'd0;
    else if (m < 22) return 8'd1;
    else if (m < 23) return 8'd2;
    else if (m < 43) return 8'd3;
    else if (m < 45) return 8'd4;
    else             return 8'd5;
  endfunction

  initial begin
    logic [5:0] seq2 [0:9];
    seq2 = '{6'b100001, 6'b100001, 6'b100001, 6'b100001, 6'b100001,
             6'b100010, 6'b100010, 6'b100100, 6'b001100, 6'b001100};

    // Reset state, then rest in NS green with no demand
    step(1);
    chk("rst_lights", 8'(lights), 8'b00100001);
    chk("rst_phase", 8'(phase), 8'd0);
    chk("rst_walk_ns", 8'(walk_ns), 8'd0);
    chk("rst_walk_ew", 8'(walk_ew), 8'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      chk("idle_lights", 8'(lights), 8'b00100001);
      step(1);
    end
    chk("idle_phase", 8'(phase), 8'd0);
    chk("idle_walk", 8'({walk_ns, walk_ew}), 8'd0);

    // EW demand only: min green then yellow, all-red, EW green
    do_reset();
    req_ew = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("gapout_lights", 8'(lights), 8'(seq2[i]));
      step(1);
    end

    // Both demanding: max-green cycling
    do_reset();
    req_ns = 1'b1;
    req_ew = 1'b1;
    for (int i = 0; i < 60; i++) begin
      chk("maxgreen_phase", 8'(phase), exp_phase3(i));
      step(1);
    end

    // EW ped press in NS green: walk_ew exactly 4 cycles, latch cleared on service
    do_reset();
    ped_ew = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 1) ped_ew = 1'b0;
      chk("ped_walk_ew", 8'(walk_ew), 8'((i >= 8) && (i <= 11)));
      step(1);
    end
    chk("ped_phase_ewg", 8'(phase), 8'd3);
    req_ns = 1'b1;
    step(1);
    chk("ped_phase_ewy", 8'(phase), 8'd4);
    step(2);
    chk("ped_phase_rtn", 8'(phase), 8'd5);
    ped_ns = 1'b1;
    step(1);
    ped_ns = 1'b0;
    req_ns = 1'b0;
    chk("ped_phase_nsg", 8'(phase), 8'd0);
    chk("ped_entry_walk_ns", 8'(walk_ns), 8'd1);
    step(3);
    chk("ped_walk_ns_last", 8'(walk_ns), 8'd1);
    step(1);
    chk("ped_walk_ns_end", 8'(walk_ns), 8'd0);
    step(30);
    chk("ped_latch_cleared", 8'(phase), 8'd0);

    // Preempt toward NS during EW green at elapsed 2
    do_reset();
    req_ew = 1'b1;
    step(10);
    chk("pre_phase_ewg", 8'(phase), 8'd3);
    preempt     = 1'b1;
    preempt_dir = 1'b0;
    step(1);
    chk("pre_phase_ewy", 8'(phase), 8'd4);
    step(2);
    chk("pre_phase_rtn", 8'(phase), 8'd5);
    step(1);
    chk("pre_phase_nsg", 8'(phase), 8'd0);
    step(30);
    chk("pre_hold_phase", 8'(phase), 8'd0);
    chk("pre_hold_lights", 8'(lights), 8'b00100001);
    preempt = 1'b0;
    step(1);
    chk("pre_release_phase", 8'(phase), 8'd1);

    // Preempt NS during NS yellow: RED_TO_EW returns to NS green; then direction flips to EW
    do_reset();
    req_ew = 1'b1;
    step(5);
    chk("pre2_phase_nsy", 8'(phase), 8'd1);
    preempt     = 1'b1;
    preempt_dir = 1'b0;
    step(2);
    chk("pre2_phase_rte", 8'(phase), 8'd2);
    step(1);
    chk("pre2_back_to_ns", 8'(phase), 8'd0);
    step(10);
    chk("pre2_hold_ns", 8'(phase), 8'd0);
    preempt_dir = 1'b1;
    step(1);
    chk("pre2_dir_flip", 8'(phase), 8'd1);
    step(2);
    chk("pre2_flip_rte", 8'(phase), 8'd2);
    step(1);
    chk("pre2_flip_ewg", 8'(phase), 8'd3);
    preempt = 1'b0;

    // Async reset mid EW yellow, then tick gating freezes timing
    do_reset();
    req_ew = 1'b1;
    step(8);
    chk("rst2_phase_ewg", 8'(phase), 8'd3);
    req_ew = 1'b0;
    req_ns = 1'b1;
    step(5);
    chk("rst2_phase_ewy", 8'(phase), 8'd4);
    #2 reset_n = 1'b0;
    #1;
    chk("rst2_async_lights", 8'(lights), 8'b00100001);
    chk("rst2_async_phase", 8'(phase), 8'd0);
    step(1);
    tick    = 1'b0;
    req_ns  = 1'b0;
    req_ew  = 1'b1;
    reset_n = 1'b1;
    step(10);
    chk("tick0_frozen", 8'(phase), 8'd0);
    tick = 1'b1;
    step(4);
    chk("tick_min_not_yet", 8'(phase), 8'd0);
    step(1);
    chk("tick_min_done", 8'(phase), 8'd1);
    tick = 1'b0;
    step(5);
    chk("tick0_yellow_held", 8'(phase), 8'd1);
    tick = 1'b1;
    step(2);
    chk("tick_yellow_done", 8'(phase), 8'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
